// File: rtl/dsram_if.sv
`default_nettype none
// ============================================================================
// Module      : dsram_if
// Description : Data-side sram-like bus (req / addr_ok / data_ok) between
//               the MEM-stage initiator and a responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dsram_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0]        data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Initiator side (MEM stage)
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  // Responder side
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dsram_responder.sv
`default_nettype none
// ============================================================================
// Module      : dsram_responder
// Description : Responder for the data-side sram-like bus. Applies writes to
//               a local word array and returns in-order completions a fixed
//               LATENCY after acceptance, with at most MAX_OUT outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module dsram_responder #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int MAX_OUT   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  dsram_if.slave                         bus,
  input  logic                           stall_i,
  output logic [$clog2(MAX_OUT+1)-1:0]   inflight_o
);

  localparam int                 c_IDX_W   = $clog2(MEM_WORDS);
  localparam int                 c_CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUT);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

  logic [DATA_W-1:0]  r_mem [MEM_WORDS];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_rd;
  logic [DATA_W-1:0]  r_data [LATENCY];
  logic [c_CNT_W-1:0] r_inflight;

  logic               w_addr_ok;
  logic               w_accept;
  logic               w_retire;
  logic               w_is_rd;
  logic [c_IDX_W-1:0] w_idx;
  logic [DATA_W-1:0]  w_rd_word;
  logic               w_unused;

  // The oldest pipeline stage is the one completing this cycle; its retirement
  // frees a slot, so a full responder can still accept in the same cycle.
  assign w_retire  = r_vld[LATENCY-1];
  assign w_addr_ok = bus.data_req & ~stall_i & ~rst &
                     ((r_inflight < c_MAX_OUT) | w_retire);
  assign w_accept  = bus.data_req & w_addr_ok;
  assign w_is_rd   = w_accept & ~bus.data_wr;

  // Word index only; byte offset and upper address bits wrap modulo the array.
  assign w_idx     = bus.data_addr[c_IDX_W+1:2];
  assign w_rd_word = r_mem[w_idx];

  // Size is informational (strobes govern writes) and out-of-range address
  // bits are intentionally ignored.
  assign w_unused  = ^{bus.data_size, bus.data_addr[ADDR_W-1:c_IDX_W+2],
                       bus.data_addr[1:0]};

  assign bus.data_addr_ok = w_addr_ok;
  assign bus.data_data_ok = r_vld[LATENCY-1];
  assign bus.data_rdata   = (r_vld[LATENCY-1] & r_rd[LATENCY-1]) ?
                            r_data[LATENCY-1] : '0;
  assign inflight_o       = r_inflight;

  // Byte-lane write into the local array on an accepted write (no reset).
  always_ff @(posedge clk) begin
    if (w_accept && bus.data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response shift register: stage 0 captures the accepted request, the last
  // stage drives the completion. Reads sample the array at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_rd  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_accept;
      r_rd[0]   <= w_is_rd;
      r_data[0] <= w_is_rd ? w_rd_word : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_rd[i]   <= r_rd[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Outstanding counter: +1 on accept, -1 on completion, unchanged on both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_inflight <= r_inflight + c_ONE;
        2'b01:   r_inflight <= r_inflight - c_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsram_responder
// Description : Self-checking bench for dsram_responder. A negedge monitor
//               records accepted requests into a scoreboard (with a reference
//               memory) and compares every completion's data and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsram_responder;

  localparam int c_LATENCY = 2;
  localparam int c_MAX_OUT = 2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic [1:0]  inflight_o;

  int          checks;
  int          failures;
  int          cyc_cnt;
  logic [31:0] last_rdata;
  logic [31:0] m_mem [1024];
  exp_t        sb [$];
  exp_t        e;

  dsram_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dsram_responder #(
    .ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024),
    .LATENCY(c_LATENCY), .MAX_OUT(c_MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_i(stall_i), .inflight_o(inflight_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for completion-latency checks
  always @(posedge clk) cyc_cnt++;

  // Monitor: retire completions against the scoreboard, then log new accepts
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_data_ok) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_data_ok: data_ok=1 rdata=%h at cycle %0d, required no completion",
                   bus.data_rdata, cyc_cnt);
        end else begin
          e = sb.pop_front();
          last_rdata = bus.data_rdata;
          if (bus.data_rdata !== e.data || cyc_cnt != e.cyc + c_LATENCY) begin
            failures++;
            $display("FAIL completion: rdata=%h cycle=%0d, required rdata=%h cycle=%0d",
                     bus.data_rdata, cyc_cnt, e.data, e.cyc + c_LATENCY);
          end
        end
      end
      if (bus.data_req && bus.data_addr_ok) begin
        if (bus.data_wr) begin
          for (int b = 0; b < 4; b++)
            if (bus.data_wstrb[b]) m_mem[bus.data_addr[11:2]][8*b +: 8] = bus.data_wdata[8*b +: 8];
          sb.push_back('{data: 32'h0, cyc: cyc_cnt});
        end else begin
          sb.push_back('{data: m_mem[bus.data_addr[11:2]], cyc: cyc_cnt});
        end
      end
    end
  end

  // Issue one request (caller sits just after a rising edge); bounded wait
  task automatic do_req(input logic wr, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wd);
    bit acc = 1'b0;
    bus.data_req   = 1'b1;
    bus.data_wr    = wr;
    bus.data_size  = 2'd2;
    bus.data_addr  = addr;
    bus.data_wstrb = strb;
    bus.data_wdata = wd;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (bus.data_addr_ok) acc = 1'b1;
      @(posedge clk); #1;
    end
    bus.data_req = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: addr=%h not accepted within 20 cycles", addr);
    end
  endtask

  // Wait until every scoreboard entry has completed; bounded
  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d completions outstanding, required 0", name, sb.size());
    end
    checks++;
    if (inflight_o !== 2'd0) begin
      failures++;
      $display("FAIL %s_inflight_idle: inflight=%0d, required 0", name, inflight_o);
    end
  endtask

  task automatic test_reset();
    int ok_seen = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.data_req = 1'b1;
    #1;
    checks++;
    if (bus.data_addr_ok !== 1'b0 || bus.data_data_ok !== 1'b0 ||
        bus.data_rdata !== 32'h0 || inflight_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: addr_ok=%b data_ok=%b rdata=%h inflight=%0d, required all 0",
               bus.data_addr_ok, bus.data_data_ok, bus.data_rdata, inflight_o);
    end
    bus.data_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // read that will be killed by reset just as it completes
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_accept: addr_ok=%b, required 1", bus.data_addr_ok);
    end
    @(posedge clk); #1;
    bus.data_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.data_data_ok !== 1'b1 || inflight_o !== 2'd1) begin
      failures++;
      $display("FAIL reset_pre_state: data_ok=%b inflight=%0d, required 1 and 1",
               bus.data_data_ok, inflight_o);
    end
    rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (bus.data_data_ok !== 1'b0 || bus.data_rdata !== 32'h0 || inflight_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_async: data_ok=%b rdata=%h inflight=%0d, required 0 0 0",
               bus.data_data_ok, bus.data_rdata, inflight_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.data_data_ok) ok_seen++;
    end
    @(posedge clk); #1;
    checks++;
    if (ok_seen != 0 || inflight_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_release: data_ok pulses=%0d inflight=%0d, required 0 and 0",
               ok_seen, inflight_o);
    end
  endtask

  task automatic test_write_read();
    do_req(1'b1, 32'h8000_0010, 4'b1111, 32'hAABB_CCDD);
    do_req(1'b0, 32'h8000_0010, 4'b0000, 32'h0);
    drain("write_read");
    checks++;
    if (last_rdata !== 32'hAABB_CCDD) begin
      failures++;
      $display("FAIL write_read_data: rdata=%h, required aabbccdd", last_rdata);
    end
  endtask

  task automatic test_partial_write();
    do_req(1'b1, 32'h8000_0010, 4'b0010, 32'h0000_1100);
    do_req(1'b0, 32'h8000_0010, 4'b0000, 32'h0);
    drain("partial");
    checks++;
    if (last_rdata !== 32'hAABB_11DD) begin
      failures++;
      $display("FAIL partial_data: rdata=%h, required aabb11dd", last_rdata);
    end
    // zero strobe: completes, no change
    do_req(1'b1, 32'h8000_0010, 4'b0000, 32'hFFFF_FFFF);
    do_req(1'b0, 32'h8000_0010, 4'b0000, 32'h0);
    drain("zero_strb");
    checks++;
    if (last_rdata !== 32'hAABB_11DD) begin
      failures++;
      $display("FAIL zero_strb_data: rdata=%h, required aabb11dd", last_rdata);
    end
  endtask

  task automatic test_stall();
    // an accepted read must still complete while stall is held
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h8000_0010;
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL stall_first_accept: addr_ok=%b, required 1", bus.data_addr_ok);
    end
    @(posedge clk); #1;
    stall_i = 1'b1;
    bus.data_addr = 32'h0000_0010;   // same word, different upper bits
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.data_addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL stall_mask: cycle %0d addr_ok=%b, required 0", i, bus.data_addr_ok);
      end
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: addr_ok=%b, required 1", bus.data_addr_ok);
    end
    @(posedge clk); #1;
    bus.data_req = 1'b0;
    drain("stall");
    checks++;
    if (last_rdata !== 32'hAABB_11DD) begin
      failures++;
      $display("FAIL stall_data: rdata=%h, required aabb11dd", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++)
      do_req(1'b1, 32'h100 + 32'(4*k), 4'b1111, 32'hC0DE_0000 + 32'(k));
    drain("b2b_fill");
    bus.data_req = 1'b1; bus.data_wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.data_addr = 32'h100 + 32'(4*(k % 4));
      @(negedge clk);
      checks++;
      if (bus.data_addr_ok !== 1'b1) begin
        failures++;
        $display("FAIL b2b_addr_ok: k=%0d addr_ok=%b, required 1", k, bus.data_addr_ok);
      end
      checks++;
      if (inflight_o !== ((k < 2) ? 2'(k) : 2'd2)) begin
        failures++;
        $display("FAIL b2b_inflight: k=%0d inflight=%0d, required %0d", k, inflight_o, (k < 2) ? k : 2);
      end
      checks++;
      if (bus.data_data_ok !== (k >= 2)) begin
        failures++;
        $display("FAIL b2b_data_ok: k=%0d data_ok=%b, required %0d", k, bus.data_data_ok, (k >= 2));
      end
      @(posedge clk); #1;
    end
    bus.data_req = 1'b0;
    drain("b2b");
    checks++;
    if (last_rdata !== 32'hC0DE_0003) begin
      failures++;
      $display("FAIL b2b_last_data: rdata=%h, required c0de0003", last_rdata);
    end
  endtask

  task automatic test_wrap();
    do_req(1'b1, 32'h0000_1000, 4'b1111, 32'h1357_9BDF);  // word index 1024
    do_req(1'b0, 32'h0000_0000, 4'b0000, 32'h0);
    drain("wrap");
    checks++;
    if (last_rdata !== 32'h1357_9BDF) begin
      failures++;
      $display("FAIL wrap_data: rdata=%h, required 13579bdf", last_rdata);
    end
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; cyc_cnt = 0; last_rdata = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    rst = 1'b1; stall_i = 1'b0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'd2;
    bus.data_addr = '0; bus.data_wstrb = '0; bus.data_wdata = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_stall();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
